// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone register/watchdog blocks: FSM encoding
// and a constant-evaluable ceiling log2.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_reg_timeout_if.sv
// Classic (non-pipelined) Wishbone bus bundle. "master" issues requests,
// "slave" answers them.
interface wb_reg_timeout_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
) ();

  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    we;
  logic [SELECT_WIDTH-1:0] sel;
  logic                    stb;
  logic                    cyc;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (
    output adr, dat_w, we, sel, stb, cyc,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, we, sel, stb, cyc,
    output dat_r, ack, err, rty
  );

endinterface

// File: rtl/wb_watchdog.sv
// Saturating cycle counter that flags the last allowed cycle of a transfer.
// TIMEOUT=0 disables expiry entirely.
module wb_watchdog
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW_RAW = clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is judged on the cycle the counter sits at TIMEOUT-1, so the
  // strobe is held for exactly TIMEOUT cycles.
  assign expire_o = (TIMEOUT != 0) && en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/wb_reg_timeout.sv
// Registered Wishbone stage between arbiter and peripheral bus; a watchdog
// ends unanswered transfers with err so the upstream master is never stuck.
module wb_reg_timeout
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_reg_timeout_if.slave  wbm,
  wb_reg_timeout_if.master wbs
);

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_w_q;
  logic                    we_q;
  logic [SELECT_WIDTH-1:0] sel_q;
  logic                    stb_q;
  logic                    cyc_q;
  logic [DATA_WIDTH-1:0]   dat_r_q;
  logic                    ack_q;
  logic                    err_q;
  logic                    rty_q;

  logic accept;
  logic slv_resp;
  logic wd_expire;

  assign accept   = (state_q == ST_IDLE) && wbm.cyc && wbm.stb;
  assign slv_resp = wbs.ack || wbs.err || wbs.rty;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (accept),
    .en_i     (state_q == ST_BUSY),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      dat_w_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
      dat_r_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
    end else begin
      cyc_q <= wbm.cyc;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rty_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            adr_q   <= wbm.adr;
            dat_w_q <= wbm.dat_w;
            we_q    <= wbm.we;
            sel_q   <= wbm.sel;
            stb_q   <= 1'b1;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Abort outranks a real response, which outranks the watchdog.
          if (!wbm.cyc) begin
            stb_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else if (slv_resp) begin
            dat_r_q <= wbs.dat_r;
            ack_q   <= wbs.ack;
            err_q   <= wbs.err;
            rty_q   <= wbs.rty;
            stb_q   <= 1'b0;
            state_q <= ST_RESP;
          end else if (wd_expire) begin
            err_q   <= 1'b1;
            stb_q   <= 1'b0;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          stb_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wbs.adr   = adr_q;
  assign wbs.dat_w = dat_w_q;
  assign wbs.we    = we_q;
  assign wbs.sel   = sel_q;
  assign wbs.stb   = stb_q;
  assign wbs.cyc   = cyc_q;

  assign wbm.dat_r = dat_r_q;
  assign wbm.ack   = ack_q;
  assign wbm.err   = err_q;
  assign wbm.rty   = rty_q;

endmodule
